fperm_res_capture: RTL and testbench

- Receiving end of the shared 68-bit tri-state result bus driven by the FP permute/seed unit.
- Tracks issued permute/div-seed/sqrt-seed operations through a fixed-latency token pipeline.
- Samples the bus in the exact slot the unit drives it and buffers the results in a small FIFO.
- Drains to writeback over a valid/ready handshake and grants issue credits so the bus is never sampled with no buffer space.

---
 rtl/fperm_res_capture.sv | 77 +++++++
 tb/tb_fperm_res_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fperm_res_capture.sv
// Capture side of the FP permute/seed result bus: fixed-latency token pipeline,
// result FIFO and issue credits so a sample never finds the buffer full.
module fperm_res_capture #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_en,
    input  logic [TAGW-1:0]            issue_tag,
    output logic                       issue_ok,
    input  logic [67:0]                bus,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [67:0]                out_data,
    output logic [TAGW-1:0]            out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = CW + 3;

    logic [LAT-1:0]                 tok_vld;
    logic [LAT-1:0][TAGW-1:0]       tok_tag;
    logic [DEPTH-1:0][67:0]         mem_d;
    logic [DEPTH-1:0][TAGW-1:0]     mem_t;
    logic [AW-1:0]                  wr_ptr, rd_ptr;
    logic [SW-1:0]                  inflight;
    logic                           take, push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + SW'(tok_vld[i]);
    end

    // Credit looks only at registered state, so out_ready never reaches issue_ok.
    assign issue_ok  = (SW'(count) + inflight) < SW'(DEPTH);
    assign take      = issue_en & issue_ok;
    assign push      = tok_vld[LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem_d[rd_ptr];
    assign out_tag   = mem_t[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tok_vld  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            tok_vld[0] <= take;
            for (int i = 1; i < LAT; i++) tok_vld[i] <= tok_vld[i-1];
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (issue_en && !issue_ok) overflow <= 1'b1;
        end
    end

    // Payload storage needs no reset; validity is carried by tok_vld and count.
    always_ff @(posedge clk) begin
        tok_tag[0] <= issue_tag;
        for (int i = 1; i < LAT; i++) tok_tag[i] <= tok_tag[i-1];
        if (push) begin
            mem_d[wr_ptr] <= bus;
            mem_t[wr_ptr] <= tok_tag[LAT-1];
        end
    end
endmodule

// File: tb/tb_fperm_res_capture.sv
// Directed bench: vector table on a LAT=1 instance, queue-model sequences on LAT=3.
module tb_fperm_res_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [67:0] bus = '0;
    logic        ie1 = 1'b0, or1 = 1'b0, ie3 = 1'b0, or3 = 1'b0;
    logic [3:0]  it1 = '0, it3 = '0, ot1, ot3;
    logic        ok1, ov1, ovf1, ok3, ov3, ovf3;
    logic [67:0] od1, od3;
    logic [2:0]  cnt1, cnt3;

    always #5 clk = ~clk;

    fperm_res_capture #(.LAT(1), .DEPTH(4), .TAGW(4)) d1 (
        .clk(clk), .rst(rst), .issue_en(ie1), .issue_tag(it1), .issue_ok(ok1),
        .bus(bus), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_tag(ot1),
        .count(cnt1), .overflow(ovf1));

    fperm_res_capture #(.LAT(3), .DEPTH(4), .TAGW(4)) d3 (
        .clk(clk), .rst(rst), .issue_en(ie3), .issue_tag(it3), .issue_ok(ok3),
        .bus(bus), .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_tag(ot3),
        .count(cnt3), .overflow(ovf3));

    always @(posedge clk) if (!rst) begin
        assert (!(d1.push && cnt1 == 3'd4)) else $error("push into full fifo (LAT=1)");
        assert (!(d3.push && cnt3 == 3'd4)) else $error("push into full fifo (LAT=3)");
    end

    int pass_n = 0, total_n = 0;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        total_n++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_n++;
    endtask

    function automatic logic [67:0] mkbus(input logic [3:0] t);
        return {t[1:0], 2'b01, 28'hC0DE000, t, 28'h5A5A5A0, t};
    endfunction

    typedef struct {
        logic        en;
        logic [3:0]  tag;
        logic [67:0] bv;
        logic        rdy;
        logic        ev;
        logic [67:0] ed;
        logic [3:0]  et;
        logic [2:0]  ec;
        logic        eok;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [3:0] tag, input logic [67:0] bv,
                                input logic rdy, input logic ev, input logic [67:0] ed,
                                input logic [3:0] et, input logic [2:0] ec, input logic eok);
        vec_t v;
        v.en = en; v.tag = tag; v.bv = bv; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.et = et; v.ec = ec; v.eok = eok;
        return v;
    endfunction

    // Reference model for the LAT=3 instance: pending tokens with their sample edge, and FIFO contents.
    typedef struct { logic [3:0] tag; int due; } pend_t;
    pend_t       pend[$];
    logic [71:0] expq[$];
    int          edge_n = 0;
    logic        exp_ovf = 1'b0;
    logic [3:0]  ntag = '0;

    function automatic logic model_ok();
        return (expq.size() + pend.size()) < 4;
    endfunction

    task automatic check3(input string tn);
        logic [71:0] h;
        chk({tn, "_cnt"}, 68'(cnt3), 68'(expq.size()));
        chk({tn, "_ok"},  68'(ok3),  68'(model_ok()));
        chk({tn, "_vld"}, 68'(ov3),  68'(expq.size() != 0));
        chk({tn, "_ovf"}, 68'(ovf3), 68'(exp_ovf));
        if (expq.size() != 0) begin
            h = expq[0];
            chk({tn, "_data"}, od3, h[67:0]);
            chk({tn, "_tag"},  68'(ot3), 68'(h[71:68]));
        end
    endtask

    task automatic step3(input string tn, input logic en, input logic rdy);
        logic okm, pushing, popping;
        logic [67:0] bv;
        pend_t p;
        okm     = model_ok();
        pushing = pend.size() > 0 && pend[0].due == edge_n;
        popping = rdy && expq.size() > 0;
        bv = pushing ? mkbus(pend[0].tag) : {4'hF, 32'hDEADBEEF, 32'($urandom)};
        bus = bv; ie3 = en; it3 = ntag; or3 = rdy;
        @(posedge clk); #1;
        if (popping) void'(expq.pop_front());
        if (pushing) begin
            p = pend.pop_front();
            expq.push_back({p.tag, bv});
        end
        if (en) begin
            if (okm) begin
                pend.push_back('{ntag, edge_n + 3});
                ntag++;
            end else exp_ovf = 1'b1;
        end
        edge_n++;
        ie3 = 1'b0;
        check3(tn);
    endtask

    task automatic do_reset();
        rst = 1'b1; ie1 = 0; ie3 = 0; or1 = 0; or3 = 0;
        #2;
        chk("rst_cnt1", 68'(cnt1), 68'd0);
        chk("rst_ok1",  68'(ok1),  68'd1);
        chk("rst_vld1", 68'(ov1),  68'd0);
        chk("rst_ovf1", 68'(ovf1), 68'd0);
        chk("rst_cnt3", 68'(cnt3), 68'd0);
        chk("rst_ok3",  68'(ok3),  68'd1);
        chk("rst_ovf3", 68'(ovf3), 68'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pend.delete(); expq.delete(); exp_ovf = 1'b0;
    endtask

    vec_t vec[$];

    initial begin
        vec.push_back(mk(1, 3,  68'd0,                      0, 0, 68'd0,                      0,  0, 1));
        vec.push_back(mk(0, 0,  68'h3_0123_4567_89AB_CDEF,  0, 1, 68'h3_0123_4567_89AB_CDEF,  3,  1, 1));
        vec.push_back(mk(0, 0,  68'd0,                      1, 0, 68'd0,                      0,  0, 1));
        vec.push_back(mk(1, 5,  68'd0,                      0, 0, 68'd0,                      0,  0, 1));
        vec.push_back(mk(1, 6,  mkbus(5),                   0, 1, mkbus(5),                   5,  1, 1));
        vec.push_back(mk(1, 7,  mkbus(6),                   0, 1, mkbus(5),                   5,  2, 1));
        vec.push_back(mk(1, 8,  mkbus(7),                   0, 1, mkbus(5),                   5,  3, 0));
        vec.push_back(mk(0, 0,  mkbus(8),                   0, 1, mkbus(5),                   5,  4, 0));
        vec.push_back(mk(0, 0,  68'd0,                      1, 1, mkbus(6),                   6,  3, 1));
        vec.push_back(mk(1, 9,  68'd0,                      1, 1, mkbus(7),                   7,  2, 1));
        vec.push_back(mk(0, 0,  mkbus(9),                   1, 1, mkbus(8),                   8,  2, 1));
        vec.push_back(mk(0, 0,  68'd0,                      1, 1, mkbus(9),                   9,  1, 1));
        vec.push_back(mk(0, 0,  68'd0,                      1, 0, 68'd0,                      0,  0, 1));
        vec.push_back(mk(1, 10, 68'd0,                      1, 0, 68'd0,                      0,  0, 1));
        vec.push_back(mk(1, 11, mkbus(10),                  1, 1, mkbus(10),                  10, 1, 1));
        vec.push_back(mk(1, 12, mkbus(11),                  1, 1, mkbus(11),                  11, 1, 1));
        vec.push_back(mk(0, 0,  mkbus(12),                  1, 1, mkbus(12),                  12, 1, 1));
        vec.push_back(mk(0, 0,  68'd0,                      1, 0, 68'd0,                      0,  0, 1));

        do_reset();

        for (int i = 0; i < vec.size(); i++) begin
            bus = vec[i].bv; ie1 = vec[i].en; it1 = vec[i].tag; or1 = vec[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("v%0d_vld", i), 68'(ov1),  68'(vec[i].ev));
            chk($sformatf("v%0d_cnt", i), 68'(cnt1), 68'(vec[i].ec));
            chk($sformatf("v%0d_ok", i),  68'(ok1),  68'(vec[i].eok));
            chk($sformatf("v%0d_ovf", i), 68'(ovf1), 68'd0);
            if (vec[i].ev) begin
                chk($sformatf("v%0d_data", i), od1, vec[i].ed);
                chk($sformatf("v%0d_tag", i),  68'(ot1), 68'(vec[i].et));
            end
        end
        ie1 = 0; or1 = 0;

        // LAT=3 fill with back-to-back issues and ready low
        for (int i = 0; i < 4; i++) step3("fill", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step3("fill_wait", 1'b0, 1'b0);
        chk("fill_full_cnt", 68'(cnt3), 68'd4);
        chk("fill_full_ok",  68'(ok3),  68'd0);

        // Full FIFO drains while new samples land; order held across pointer wrap
        for (int i = 0; i < 24; i++) step3("wrap", model_ok(), 1'b1);
        for (int i = 0; i < 24; i++) step3("rand", model_ok(), 1'($urandom_range(0, 3) != 0));

        // Illegal issue while full sets sticky overflow
        for (int i = 0; i < 8; i++) step3("refill", model_ok(), 1'b0);
        step3("illegal", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step3("ovf_hold", 1'b0, 1'b0);
        do_reset();

        // Mid-cycle reset with count=2 and two tokens in flight
        for (int i = 0; i < 5; i++) step3("pre_rst", model_ok(), 1'b0);
        chk("pre_rst_cnt", 68'(cnt3), 68'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_cnt", 68'(cnt3), 68'd0);
        chk("async_vld", 68'(ov3),  68'd0);
        chk("async_ok",  68'(ok3),  68'd1);
        #1 rst = 1'b0;
        pend.delete(); expq.delete(); exp_ovf = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step3("post_rst", 1'b0, 1'b0);
            bus = mkbus(4'd2);
        end

        // Empty FIFO, ready held: no bypass, pop one edge after the push
        step3("nobyp_iss", 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step3("nobyp", 1'b0, 1'b1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
